// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU command sequencer: sequencer state
//   encoding, ALU opcodes and the datapath width.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int DW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_ROL = 1'b1
  } op_t;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_alu
//   Purely combinational 5-bit AND / rotate-left ALU.
//   Ports:
//     i_a, i_b  : operands (DW bits)
//     i_op      : 0 = AND, 1 = ROL (rotate i_a left by i_b[2:0])
//     o_r       : result
//     o_cf      : carry flag, always 0 (no operation produces a carry)
//     o_sf      : sign flag, MSB of the result
//     o_zf      : zero flag, result == 0
// ---------------------------------------------------------------------------
module alu_seq_ctrl_alu
  import alu_seq_pkg::*;
(
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic          i_op,
  output logic [DW-1:0] o_r,
  output logic          o_cf,
  output logic          o_sf,
  output logic          o_zf
);

  logic [2:0]      w_amt;
  logic [2*DW-1:0] w_dbl;
  logic [DW-1:0]   w_rot;

  // A 5-bit rotation is periodic in 5, so amounts 5..7 fold onto 0..2.
  // Shifting a doubled copy of the operand leaves the rotated word in the
  // upper half.
  always_comb begin
    w_amt = (i_b[2:0] >= 3'd5) ? (i_b[2:0] - 3'd5) : i_b[2:0];
    w_dbl = {i_a, i_a} << w_amt;
    w_rot = w_dbl[2*DW-1:DW];
  end

  assign o_r  = (i_op == OP_ROL) ? w_rot : (i_a & i_b);
  assign o_cf = 1'b0;
  assign o_sf = o_r[DW-1];
  assign o_zf = (o_r == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Command sequencer around the 5-bit AND/ROL ALU. Accepts one command per
//   cmd handshake, applies the operation cmd_iter+1 times feeding the result
//   back as the next A operand, then holds the final result and flags on the
//   rsp port until the consumer accepts it.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//     cmd_a, cmd_b, cmd_op  : initial A operand, constant B operand, opcode
//     cmd_iter              : iteration count minus one
//     rsp_valid/rsp_ready   : response handshake (valid only in DONE)
//     rsp_r                 : final result
//     rsp_cf/sf/zf          : ALU flags of the last iteration
//     rsp_zseen             : ZF seen on any iteration of this command
//     busy                  : sequencer is not IDLE
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     cmd_a,
  input  logic [DW-1:0]     cmd_b,
  input  logic              cmd_op,
  input  logic [ITER_W-1:0] cmd_iter,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_r,
  output logic              rsp_cf,
  output logic              rsp_sf,
  output logic              rsp_zf,
  output logic              rsp_zseen,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_acc;
  logic [DW-1:0]     r_b;
  logic              r_op;
  logic [ITER_W-1:0] r_cnt;
  logic              r_cf;
  logic              r_sf;
  logic              r_zf;
  logic              r_zseen;

  logic [DW-1:0]     w_r;
  logic              w_cf;
  logic              w_sf;
  logic              w_zf;

  alu_seq_ctrl_alu u_alu (
    .i_a  (r_acc),
    .i_b  (r_b),
    .i_op (r_op),
    .o_r  (w_r),
    .o_cf (w_cf),
    .o_sf (w_sf),
    .o_zf (w_zf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next is given its hold value before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (cmd_valid)      w_next = S_EXEC;
      S_EXEC: if (r_cnt == '0)    w_next = S_DONE;
      S_DONE: if (rsp_ready)      w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, not just the FSM, because the
  // response outputs are observed directly and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
      r_cnt   <= '0;
      r_cf    <= 1'b0;
      r_sf    <= 1'b0;
      r_zf    <= 1'b0;
      r_zseen <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_acc   <= cmd_a;
            r_b     <= cmd_b;
            r_op    <= cmd_op;
            r_cnt   <= cmd_iter;
            r_zseen <= 1'b0;
          end
        end
        S_EXEC: begin
          r_acc   <= w_r;
          r_cf    <= w_cf;
          r_sf    <= w_sf;
          r_zf    <= w_zf;
          r_zseen <= r_zseen | w_zf;
          // The last iteration leaves cnt at zero instead of wrapping.
          if (r_cnt != '0) r_cnt <= r_cnt - ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decode registered state only.
  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  assign rsp_r     = r_acc;
  assign rsp_cf    = r_cf;
  assign rsp_sf    = r_sf;
  assign rsp_zf    = r_zf;
  assign rsp_zseen = r_zseen;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Self-checking bench for alu_seq_ctrl: directed vector table, hand-written
//   multi-cycle sequences (backpressure, reset abort, back-to-back) and
//   randomized commands checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_a;
  logic [4:0] cmd_b;
  logic       cmd_op;
  logic [2:0] cmd_iter;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_r;
  logic       rsp_cf;
  logic       rsp_sf;
  logic       rsp_zf;
  logic       rsp_zseen;
  logic       busy;

  alu_seq_ctrl #(.ITER_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_iter  (cmd_iter),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_cf    (rsp_cf),
    .rsp_sf    (rsp_sf),
    .rsp_zf    (rsp_zf),
    .rsp_zseen (rsp_zseen),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Handshake monitors: accept cycle numbers and accepted responses.
  int         cyc = 0;
  int         acc_cyc[$];
  logic [4:0] rsp_q[$];

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
    if (rst_n && rsp_valid && rsp_ready) rsp_q.push_back(rsp_r);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: apply the operation iter+1 times with plain integer
  // arithmetic; a 5-bit rotation by k equals rotation by k mod 5.
  function automatic void model(input logic op, input int a, input int b,
                                input int iter, output int r, output int zs);
    int acc;
    int k;
    acc = a;
    zs  = 0;
    k   = (b % 8) % 5;
    for (int i = 0; i <= iter; i++) begin
      if (op) acc = ((acc << k) | (acc >> (5 - k))) & 31;
      else    acc = acc & b;
      if (acc == 0) zs = 1;
    end
    r = acc;
  endfunction

  // Issue one command with rsp_ready held high and check latency, result,
  // flags and that DONE lasts exactly one cycle.
  task automatic run_cmd(input logic op, input logic [4:0] a,
                         input logic [4:0] b, input logic [2:0] iter,
                         input logic [4:0] er, input logic esf,
                         input logic ezf, input logic ezs, input string tag);
    int n;
    @(negedge clk);
    check({tag, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_iter = iter;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, iter + 1);
    check({tag, " r"},       rsp_r, er);
    check({tag, " cf"},      rsp_cf, 0);
    check({tag, " sf"},      rsp_sf, esf);
    check({tag, " zf"},      rsp_zf, ezf);
    check({tag, " zseen"},   rsp_zseen, ezs);
    check({tag, " busy"},    busy, 1);
    @(negedge clk);
    check({tag, " done_1cyc"}, rsp_valid, 0);
    check({tag, " idle"},      cmd_ready, 1);
  endtask

  typedef struct {
    logic       op;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] iter;
    logic [4:0] r;
    logic       sf;
    logic       zf;
    logic       zs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int na;
    int mr;
    int mz;
    logic       rop;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [2:0] ri;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 1'b0;
    cmd_iter = '0; rsp_ready = 1'b0;

    vecs[0] = '{1'b1, 5'b00001, 5'b00001, 3'd3, 5'b10000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'b10110, 5'b01001, 3'd0, 5'b00000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 5'b11111, 5'b11110, 3'd7, 5'b11110, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'b10110, 5'b00011, 3'd0, 5'b10101, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'b00001, 5'b00111, 3'd1, 5'b10000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 5'b11111, 5'b00000, 3'd2, 5'b00000, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst busy",      busy, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_r",     rsp_r, 0);
    check("rst flags",     {rsp_cf, rsp_sf, rsp_zf, rsp_zseen}, 0);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i])
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].iter, vecs[i].r,
              vecs[i].sf, vecs[i].zf, vecs[i].zs, $sformatf("vec%0d", i));

    // Backpressure: response held for 5 cycles, a new command is ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 5'b00011; cmd_b = 5'b00010;
    cmd_iter = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp latency", n, 2);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_a = 5'b11111; cmd_b = 5'b11111;
    cmd_iter = 3'd0;
    na = acc_cyc.size();
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_r",     rsp_r, 5'b10001);
      check("bp sf",        rsp_sf, 1);
      check("bp cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp no accept", acc_cyc.size(), na);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp released", rsp_valid, 0);
    check("bp rsp taken", rsp_q[$], 5'b10001);

    // Reset in the middle of EXEC aborts the command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 5'b00001; cmd_b = 5'b00001;
    cmd_iter = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy before", busy, 1);
    na = rsp_q.size();
    #2 rst_n = 1'b0;
    #1;
    check("abort cmd_ready", cmd_ready, 1);
    check("abort busy",      busy, 0);
    check("abort rsp_valid", rsp_valid, 0);
    check("abort rsp_r",     rsp_r, 0);
    check("abort flags",     {rsp_cf, rsp_sf, rsp_zf, rsp_zseen}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("abort no rsp_valid", rsp_valid, 0);
    end
    check("abort cmd_ready after", cmd_ready, 1);
    check("abort no response", rsp_q.size(), na);

    // Back-to-back with cmd_valid held high.
    acc_cyc.delete();
    rsp_q.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_a = 5'b11111; cmd_b = 5'b00101;
    cmd_iter = 3'd0;
    @(negedge clk);
    cmd_op = 1'b1; cmd_a = 5'b10000; cmd_b = 5'b00001; cmd_iter = 3'd0;
    n = 0;
    while (acc_cyc.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_q.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b accepts", acc_cyc.size(), 2);
    check("b2b responses", rsp_q.size(), 2);
    if (acc_cyc.size() == 2) check("b2b interval", acc_cyc[1] - acc_cyc[0], 3);
    if (rsp_q.size() == 2) begin
      check("b2b rsp0", rsp_q[0], 5'b00101);
      check("b2b rsp1", rsp_q[1], 5'b00001);
    end

    // Randomized commands against the reference model.
    for (int t = 0; t < 30; t++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      ri  = 3'($urandom_range(0, 7));
      model(rop, int'(ra), int'(rb), int'(ri), mr, mz);
      run_cmd(rop, ra, rb, ri, 5'(mr), (mr >= 16), (mr == 0), (mz != 0),
              $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
